// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the hardwired control sequencer: IR field layout,
// opcode values, state encoding, strobe bundle and opcode classification.
package control_sequencer_pkg;

   localparam int NUM_REGS  = 16;
   localparam int REG_IDX_W = 4;
   localparam int OP_W      = 5;
   localparam int IR_W      = 32;

   localparam int OP_LSB = 27;
   localparam int RA_LSB = 23;
   localparam int RB_LSB = 19;
   localparam int RC_LSB = 15;

   localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
   localparam logic [OP_W-1:0] OP_SHL  = 5'b01011;
   localparam logic [OP_W-1:0] OP_ADDI = 5'b01100;
   localparam logic [OP_W-1:0] OP_ORI  = 5'b01110;
   localparam logic [OP_W-1:0] OP_DIV  = 5'b01111;
   localparam logic [OP_W-1:0] OP_MUL  = 5'b10000;
   localparam logic [OP_W-1:0] OP_NEG  = 5'b10001;
   localparam logic [OP_W-1:0] OP_NOT  = 5'b10010;
   localparam logic [OP_W-1:0] OP_MFLO = 5'b11000;
   localparam logic [OP_W-1:0] OP_MFHI = 5'b11001;
   localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
   localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_T0,
      ST_T1,
      ST_T2,
      ST_T3,
      ST_T4,
      ST_T5,
      ST_T6,
      ST_HALTED
   } state_t;

   typedef enum logic [3:0] {
      CLS_ALU3,
      CLS_IMM,
      CLS_MULDIV,
      CLS_UNARY,
      CLS_MFHI,
      CLS_MFLO,
      CLS_NOP,
      CLS_HALT,
      CLS_ILLEGAL
   } op_class_t;

   typedef struct packed {
      logic pc_out;
      logic zhigh_out;
      logic zlow_out;
      logic mdr_out;
      logic hi_out;
      logic lo_out;
      logic c_out;
      logic mar_in;
      logic pc_in;
      logic mdr_in;
      logic ir_in;
      logic y_in;
      logic hi_in;
      logic lo_in;
      logic zhigh_in;
      logic zlow_in;
      logic inc_pc;
      logic read;
   } strobe_t;

   function automatic op_class_t decode_class(input logic [OP_W-1:0] op);
      op_class_t cls;
      if (op >= OP_ADD && op <= OP_SHL)
         cls = CLS_ALU3;
      else if (op >= OP_ADDI && op <= OP_ORI)
         cls = CLS_IMM;
      else if (op == OP_MUL || op == OP_DIV)
         cls = CLS_MULDIV;
      else if (op == OP_NEG || op == OP_NOT)
         cls = CLS_UNARY;
      else if (op == OP_MFHI)
         cls = CLS_MFHI;
      else if (op == OP_MFLO)
         cls = CLS_MFLO;
      else if (op == OP_NOP)
         cls = CLS_NOP;
      else if (op == OP_HALT)
         cls = CLS_HALT;
      else
         cls = CLS_ILLEGAL;
      return cls;
   endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Strobe bundle between the control sequencer (master) and the DataPath (slave).
interface control_sequencer_if;
   import control_sequencer_pkg::*;

   logic                 start;
   logic [IR_W-1:0]      IR;
   logic                 run;
   logic                 illegal;
   logic                 PCout, Zhighout, Zlowout, MDRout;
   logic                 HIout, LOout, Cout;
   logic                 MARin, PCin, MDRin, IRin, Yin;
   logic                 HIin, LOin, ZHighIn, ZLowIn;
   logic                 IncPC, Read;
   logic [OP_W-1:0]      opcode;
   logic [NUM_REGS-1:0]  R_in;
   logic [NUM_REGS-1:0]  R_out;

   modport master (
      input  start, IR,
      output run, illegal,
      output PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Cout,
      output MARin, PCin, MDRin, IRin, Yin, HIin, LOin, ZHighIn, ZLowIn,
      output IncPC, Read, opcode, R_in, R_out
   );

   modport slave (
      output start, IR,
      input  run, illegal,
      input  PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Cout,
      input  MARin, PCin, MDRin, IRin, Yin, HIin, LOin, ZHighIn, ZLowIn,
      input  IncPC, Read, opcode, R_in, R_out
   );

endinterface

// File: rtl/control_sequencer_reg_select_encode.sv
// Turns the Ra/Rb/Rc field chosen by gra/grb/grc into one-hot GPR load and
// bus-drive vectors; both stay zero unless rin/rout is asserted.
module reg_select_encode
   import control_sequencer_pkg::*;
(
   input  logic [3*REG_IDX_W-1:0] fields,
   input  logic                   gra,
   input  logic                   grb,
   input  logic                   grc,
   input  logic                   rin,
   input  logic                   rout,
   output logic [NUM_REGS-1:0]    r_in,
   output logic [NUM_REGS-1:0]    r_out
);

   // fields holds IR[26:15]: Ra in the top nibble, Rc in the bottom one
   localparam int FRA = RA_LSB - RC_LSB;
   localparam int FRB = RB_LSB - RC_LSB;

   logic [REG_IDX_W-1:0] sel;

   always_comb begin
      sel = '0;
      if (gra)
         sel = fields[FRA +: REG_IDX_W];
      else if (grb)
         sel = fields[FRB +: REG_IDX_W];
      else if (grc)
         sel = fields[0 +: REG_IDX_W];
   end

   generate
      for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_dec
         assign r_in[gi]  = rin  && (sel == REG_IDX_W'(gi));
         assign r_out[gi] = rout && (sel == REG_IDX_W'(gi));
      end
   endgenerate

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch in T0-T2, then opcode-dependent execute steps,
// with Moore strobes decoded from the state register and the IR fields.
module control_sequencer
   import control_sequencer_pkg::*;
(
   input  logic                clock,
   input  logic                clear,
   control_sequencer_if.master bus
);

   state_t    state_reg;
   state_t    state_next;
   strobe_t   strobe;
   op_class_t op_class;
   logic      gra, grb, grc, rin, rout;
   logic      alu_step;
   logic      illegal_now;

   assign op_class = decode_class(bus.IR[OP_LSB +: OP_W]);

   always_ff @(posedge clock or negedge clear) begin
      if (!clear)
         state_reg <= ST_IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next  = state_reg;
      strobe      = '0;
      gra         = 1'b0;
      grb         = 1'b0;
      grc         = 1'b0;
      rin         = 1'b0;
      rout        = 1'b0;
      alu_step    = 1'b0;
      illegal_now = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (bus.start)
               state_next = ST_T0;
         end
         ST_T0: begin
            strobe.pc_out  = 1'b1;
            strobe.mar_in  = 1'b1;
            strobe.inc_pc  = 1'b1;
            strobe.zlow_in = 1'b1;
            state_next     = ST_T1;
         end
         ST_T1: begin
            strobe.zlow_out = 1'b1;
            strobe.pc_in    = 1'b1;
            strobe.read     = 1'b1;
            strobe.mdr_in   = 1'b1;
            state_next      = ST_T2;
         end
         ST_T2: begin
            strobe.mdr_out = 1'b1;
            strobe.ir_in   = 1'b1;
            state_next     = ST_T3;
         end
         ST_T3: begin
            state_next = ST_T4;
            case (op_class)
               CLS_ALU3, CLS_IMM: begin
                  grb = 1'b1; rout = 1'b1; strobe.y_in = 1'b1;
               end
               CLS_MULDIV: begin
                  gra = 1'b1; rout = 1'b1; strobe.y_in = 1'b1;
               end
               CLS_UNARY: begin
                  grb = 1'b1; rout = 1'b1; alu_step = 1'b1; strobe.zlow_in = 1'b1;
               end
               CLS_MFHI: begin
                  strobe.hi_out = 1'b1; gra = 1'b1; rin = 1'b1; state_next = ST_T0;
               end
               CLS_MFLO: begin
                  strobe.lo_out = 1'b1; gra = 1'b1; rin = 1'b1; state_next = ST_T0;
               end
               CLS_NOP:  state_next = ST_T0;
               CLS_HALT: state_next = ST_HALTED;
               default: begin
                  illegal_now = 1'b1;
                  state_next  = ST_T0;
               end
            endcase
         end
         ST_T4: begin
            state_next = ST_T5;
            case (op_class)
               CLS_ALU3: begin
                  grc = 1'b1; rout = 1'b1; alu_step = 1'b1; strobe.zlow_in = 1'b1;
               end
               CLS_IMM: begin
                  strobe.c_out = 1'b1; alu_step = 1'b1; strobe.zlow_in = 1'b1;
               end
               CLS_MULDIV: begin
                  grb = 1'b1; rout = 1'b1; alu_step = 1'b1;
                  strobe.zhigh_in = 1'b1; strobe.zlow_in = 1'b1;
               end
               CLS_UNARY: begin
                  strobe.zlow_out = 1'b1; gra = 1'b1; rin = 1'b1; state_next = ST_T0;
               end
               default: state_next = ST_T0;
            endcase
         end
         ST_T5: begin
            state_next = ST_T0;
            case (op_class)
               CLS_ALU3, CLS_IMM: begin
                  strobe.zlow_out = 1'b1; gra = 1'b1; rin = 1'b1;
               end
               CLS_MULDIV: begin
                  strobe.zlow_out = 1'b1; strobe.lo_in = 1'b1; state_next = ST_T6;
               end
               default: ;
            endcase
         end
         ST_T6: begin
            state_next = ST_T0;
            if (op_class == CLS_MULDIV) begin
               strobe.zhigh_out = 1'b1;
               strobe.hi_in     = 1'b1;
            end
         end
         ST_HALTED: state_next = ST_HALTED;
         default:   state_next = ST_IDLE;
      endcase
   end

   reg_select_encode u_reg_select (
      .fields (bus.IR[RA_LSB + REG_IDX_W - 1 : RC_LSB]),
      .gra    (gra),
      .grb    (grb),
      .grc    (grc),
      .rin    (rin),
      .rout   (rout),
      .r_in   (bus.R_in),
      .r_out  (bus.R_out)
   );

   assign bus.run      = (state_reg != ST_IDLE) && (state_reg != ST_HALTED);
   assign bus.illegal  = illegal_now;
   assign bus.opcode   = alu_step ? bus.IR[OP_LSB +: OP_W] : '0;
   assign bus.PCout    = strobe.pc_out;
   assign bus.Zhighout = strobe.zhigh_out;
   assign bus.Zlowout  = strobe.zlow_out;
   assign bus.MDRout   = strobe.mdr_out;
   assign bus.HIout    = strobe.hi_out;
   assign bus.LOout    = strobe.lo_out;
   assign bus.Cout     = strobe.c_out;
   assign bus.MARin    = strobe.mar_in;
   assign bus.PCin     = strobe.pc_in;
   assign bus.MDRin    = strobe.mdr_in;
   assign bus.IRin     = strobe.ir_in;
   assign bus.Yin      = strobe.y_in;
   assign bus.HIin     = strobe.hi_in;
   assign bus.LOin     = strobe.lo_in;
   assign bus.ZHighIn  = strobe.zhigh_in;
   assign bus.ZLowIn   = strobe.zlow_in;
   assign bus.IncPC    = strobe.inc_pc;
   assign bus.Read     = strobe.read;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench: expected per-cycle strobe sets are queued when an instruction
// is issued and compared against the DUT outputs on each falling edge.
module tb_control_sequencer;

   typedef struct packed {
      logic        run;
      logic        illegal;
      logic [17:0] strb;
      logic [4:0]  opcode;
      logic [15:0] r_in;
      logic [15:0] r_out;
   } obs_t;

   typedef struct {
      string tag;
      obs_t  val;
   } sb_t;

   localparam logic [17:0] PCOUT    = 18'h1 << 17;
   localparam logic [17:0] ZHIGHOUT = 18'h1 << 16;
   localparam logic [17:0] ZLOWOUT  = 18'h1 << 15;
   localparam logic [17:0] MDROUT   = 18'h1 << 14;
   localparam logic [17:0] HIOUT    = 18'h1 << 13;
   localparam logic [17:0] LOOUT    = 18'h1 << 12;
   localparam logic [17:0] COUT     = 18'h1 << 11;
   localparam logic [17:0] MARIN    = 18'h1 << 10;
   localparam logic [17:0] PCIN     = 18'h1 << 9;
   localparam logic [17:0] MDRIN    = 18'h1 << 8;
   localparam logic [17:0] IRIN     = 18'h1 << 7;
   localparam logic [17:0] YIN      = 18'h1 << 6;
   localparam logic [17:0] HIIN     = 18'h1 << 5;
   localparam logic [17:0] LOIN     = 18'h1 << 4;
   localparam logic [17:0] ZHIGHIN  = 18'h1 << 3;
   localparam logic [17:0] ZLOWIN   = 18'h1 << 2;
   localparam logic [17:0] INCPC    = 18'h1 << 1;
   localparam logic [17:0] READ     = 18'h1 << 0;

   localparam logic [31:0] IR_MUL  = 32'h8130_0000;
   localparam logic [31:0] IR_ADD  = 32'h1A92_0000;
   localparam logic [31:0] IR_ADDI = 32'h61A7_FFFB;
   localparam logic [31:0] IR_MFHI = 32'hCB80_0000;
   localparam logic [31:0] IR_LD   = 32'h0000_0000;
   localparam logic [31:0] IR_NEG  = 32'h88C8_0000;
   localparam logic [31:0] IR_NOP  = 32'hD000_0000;
   localparam logic [31:0] IR_HALT = 32'hD800_0000;

   logic clock;
   logic clear;
   int   checks;
   int   passed;
   int   failed;
   sb_t  sb[$];

   control_sequencer_if bus_if ();

   control_sequencer dut (
      .clock (clock),
      .clear (clear),
      .bus   (bus_if)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   function automatic obs_t mk(input logic run, input logic ill, input logic [17:0] strb,
                               input logic [4:0] op, input logic [15:0] rin,
                               input logic [15:0] rout);
      obs_t o;
      o.run     = run;
      o.illegal = ill;
      o.strb    = strb;
      o.opcode  = op;
      o.r_in    = rin;
      o.r_out   = rout;
      return o;
   endfunction

   function automatic obs_t sample();
      obs_t o;
      o.run     = bus_if.run;
      o.illegal = bus_if.illegal;
      o.strb    = {bus_if.PCout, bus_if.Zhighout, bus_if.Zlowout, bus_if.MDRout,
                   bus_if.HIout, bus_if.LOout, bus_if.Cout, bus_if.MARin,
                   bus_if.PCin, bus_if.MDRin, bus_if.IRin, bus_if.Yin,
                   bus_if.HIin, bus_if.LOin, bus_if.ZHighIn, bus_if.ZLowIn,
                   bus_if.IncPC, bus_if.Read};
      o.opcode  = bus_if.opcode;
      o.r_in    = bus_if.R_in;
      o.r_out   = bus_if.R_out;
      return o;
   endfunction

   task automatic expect_obs(input string tag, input obs_t v);
      sb_t e;
      e.tag = tag;
      e.val = v;
      sb.push_back(e);
   endtask

   task automatic push_fetch(input string name);
      expect_obs({name, "_T0"}, mk(1'b1, 1'b0, PCOUT | MARIN | INCPC | ZLOWIN, 5'd0, 16'h0, 16'h0));
      expect_obs({name, "_T1"}, mk(1'b1, 1'b0, ZLOWOUT | PCIN | READ | MDRIN, 5'd0, 16'h0, 16'h0));
      expect_obs({name, "_T2"}, mk(1'b1, 1'b0, MDROUT | IRIN, 5'd0, 16'h0, 16'h0));
   endtask

   task automatic check_one();
      sb_t  e;
      obs_t o;
      e = sb.pop_front();
      o = sample();
      checks++;
      assert (o === e.val) begin
         passed++;
      end else begin
         failed++;
         $error("FAIL %s observed=%h required=%h", e.tag, o, e.val);
      end
      $display("check %s observed=%h", e.tag, o);
   endtask

   // IR is updated just after the first (T0) check so it is stable from T3 on
   task automatic drain(input logic [31:0] ir_val);
      bit first;
      first = 1'b1;
      while (sb.size() > 0) begin
         @(negedge clock);
         check_one();
         if (first) begin
            bus_if.IR = ir_val;
            first = 1'b0;
         end
      end
   endtask

   initial begin
      checks = 0;
      passed = 0;
      failed = 0;
      clear = 1'b0;
      bus_if.start = 1'b0;
      bus_if.IR = 32'h0;

      repeat (2) @(negedge clock);
      expect_obs("reset_hold", mk(1'b0, 1'b0, 18'h0, 5'd0, 16'h0, 16'h0));
      check_one();

      clear = 1'b1;
      expect_obs("idle_0", mk(1'b0, 1'b0, 18'h0, 5'd0, 16'h0, 16'h0));
      expect_obs("idle_1", mk(1'b0, 1'b0, 18'h0, 5'd0, 16'h0, 16'h0));
      drain(32'h0);

      bus_if.start = 1'b1;
      push_fetch("mul");
      expect_obs("mul_T3", mk(1'b1, 1'b0, YIN, 5'd0, 16'h0, 16'h0004));
      expect_obs("mul_T4", mk(1'b1, 1'b0, ZHIGHIN | ZLOWIN, 5'b10000, 16'h0, 16'h0040));
      expect_obs("mul_T5", mk(1'b1, 1'b0, ZLOWOUT | LOIN, 5'd0, 16'h0, 16'h0));
      expect_obs("mul_T6", mk(1'b1, 1'b0, ZHIGHOUT | HIIN, 5'd0, 16'h0, 16'h0));
      drain(IR_MUL);

      push_fetch("add");
      expect_obs("add_T3", mk(1'b1, 1'b0, YIN, 5'd0, 16'h0, 16'h0004));
      expect_obs("add_T4", mk(1'b1, 1'b0, ZLOWIN, 5'b00011, 16'h0, 16'h0010));
      expect_obs("add_T5", mk(1'b1, 1'b0, ZLOWOUT, 5'd0, 16'h0020, 16'h0));
      drain(IR_ADD);

      push_fetch("addi");
      expect_obs("addi_T3", mk(1'b1, 1'b0, YIN, 5'd0, 16'h0, 16'h0010));
      expect_obs("addi_T4", mk(1'b1, 1'b0, COUT | ZLOWIN, 5'b01100, 16'h0, 16'h0));
      expect_obs("addi_T5", mk(1'b1, 1'b0, ZLOWOUT, 5'd0, 16'h0008, 16'h0));
      drain(IR_ADDI);

      push_fetch("mfhi");
      expect_obs("mfhi_T3", mk(1'b1, 1'b0, HIOUT, 5'd0, 16'h0080, 16'h0));
      drain(IR_MFHI);

      push_fetch("ld");
      expect_obs("ld_T3", mk(1'b1, 1'b1, 18'h0, 5'd0, 16'h0, 16'h0));
      drain(IR_LD);

      push_fetch("neg");
      expect_obs("neg_T3", mk(1'b1, 1'b0, ZLOWIN, 5'b10001, 16'h0, 16'h0200));
      expect_obs("neg_T4", mk(1'b1, 1'b0, ZLOWOUT, 5'd0, 16'h0002, 16'h0));
      drain(IR_NEG);

      // abort a mul in the middle of T4 with an asynchronous clear
      push_fetch("abort");
      expect_obs("abort_T3", mk(1'b1, 1'b0, YIN, 5'd0, 16'h0, 16'h0004));
      drain(IR_MUL);
      @(posedge clock);
      #1;
      expect_obs("abort_T4", mk(1'b1, 1'b0, ZHIGHIN | ZLOWIN, 5'b10000, 16'h0, 16'h0040));
      check_one();
      #1;
      clear = 1'b0;
      #1;
      expect_obs("abort_clear", mk(1'b0, 1'b0, 18'h0, 5'd0, 16'h0, 16'h0));
      check_one();
      @(negedge clock);
      clear = 1'b1;

      push_fetch("nop");
      expect_obs("nop_T3", mk(1'b1, 1'b0, 18'h0, 5'd0, 16'h0, 16'h0));
      drain(IR_NOP);

      push_fetch("halt");
      expect_obs("halt_T3", mk(1'b1, 1'b0, 18'h0, 5'd0, 16'h0, 16'h0));
      for (int i = 0; i < 20; i++)
         expect_obs($sformatf("halted_%0d", i), mk(1'b0, 1'b0, 18'h0, 5'd0, 16'h0, 16'h0));
      drain(IR_HALT);

      clear = 1'b0;
      #1;
      expect_obs("halt_clear", mk(1'b0, 1'b0, 18'h0, 5'd0, 16'h0, 16'h0));
      check_one();
      @(negedge clock);
      bus_if.start = 1'b0;
      clear = 1'b1;
      expect_obs("post_halt_idle_0", mk(1'b0, 1'b0, 18'h0, 5'd0, 16'h0, 16'h0));
      expect_obs("post_halt_idle_1", mk(1'b0, 1'b0, 18'h0, 5'd0, 16'h0, 16'h0));
      drain(32'h0);

      bus_if.start = 1'b1;
      push_fetch("restart");
      expect_obs("restart_T3", mk(1'b1, 1'b0, HIOUT, 5'd0, 16'h0080, 16'h0));
      drain(IR_MFHI);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
